regfile_sb: RTL
===============

Name: regfile_sb

Overview:
- Parametrised integer register file for the pipelined RISC-V core, with NRD combinational read ports and one synchronous write port.
- Adds a per-register busy scoreboard for long-latency operations (loads, mul/div): issue marks the destination busy, writeback clears it.
- Sits between decode (read + hazard check) and writeback; replaces the fixed 2-read/32x32 bank.

Parameters:
- XLEN, 32, data width in bits.
- NREGS, 32, number of architectural registers (power of two, >=2).
- NRD, 2, number of read ports (1..4).
- ZERO_REG, 1, 1: register 0 hardwired to zero; 0: register 0 is an ordinary register.
- Derived: AW = $clog2(NREGS), CW = $clog2(NREGS+1).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- rd_addr  in  NRD*AW  read addresses; port k occupies bits [k*AW +: AW].
- rd_data  out  NRD*XLEN  read data; port k occupies bits [k*XLEN +: XLEN].
- rd_busy  out  NRD  port k address has an in-flight long-latency write.
- we  in  1  write/writeback enable.
- wa  in  AW  write address.
- wd  in  XLEN  write data.
- iss_valid  in  1  long-latency op requests destination reservation.
- iss_rd  in  AW  destination register to reserve.
- iss_ready  out  1  reservation can be accepted this cycle.
- busy_cnt  out  CW  number of registers currently busy.

Behaviour:
- Reset is synchronous and active-high, on clk posedge with rst=1.
  - All registers go to 0, all busy bits to 0, busy_cnt to 0.
  - Reset overrides any same-cycle we or issue.
  - Reset asserted mid-operation drops all reservations; late writebacks after reset are ordinary writes.
- Write:
  - On posedge with we=1, mem[wa] <= wd.
  - With ZERO_REG=1 and wa=0, the write is discarded.
  - A write is legal whether or not wa is busy.
- Read:
  - Combinational, zero latency.
  - rd_data[k] = 0 if ZERO_REG and rd_addr[k]=0; otherwise mem[rd_addr[k]] (bypass rules below).
  - rd_busy[k] = busy[rd_addr[k]]; always 0 for address 0 when ZERO_REG.
- Issue ready:
  - iss_ready = !busy[iss_rd], or iss_rd=0 with ZERO_REG. WAW stalls until the prior writeback.
  - Depends only on iss_rd and state, never on iss_valid.
- Reservation:
  - Accepted when iss_valid && iss_ready.
  - On acceptance, busy[iss_rd] <= 1 at the next posedge.
  - Issue to register 0 with ZERO_REG is accepted and has no effect.
- Clear:
  - On posedge with we=1 and busy[wa]=1, busy[wa] <= 0.
- Simultaneous events:
  - Same-cycle writeback to X and accepted issue to X (only possible if X was not busy): set wins, busy[X]=1 afterwards, data still written.
  - Writeback to X and issue to Y (X != Y): both take effect.
- busy_cnt: registered population count of busy, updated each cycle by +1 / -1 / 0 / net 0 per the above. Range 0..NREGS-(ZERO_REG?1:0), so no wrap.

Optional Feature:
- Macro REGFILE_BYPASS_EN.
- Defined:
  - Write-through forwarding: if we=1, wa=rd_addr[k], and wa is not zero-reg, then rd_data[k]=wd in the same cycle.
  - rd_busy[k] is forced to 0 in that case, since the writeback completes the hazard.
- Undefined:
  - rd_data returns the pre-write value.
  - rd_busy reflects the registered busy bit; the new value is visible the cycle after the write.

Decomposition:
- Package regfile_pkg holds:
  - localparams XLEN_DEF=32 and NREGS_DEF=32.
  - typedefs word_t (logic [XLEN_DEF-1:0]) and reg_addr_t (logic [$clog2(NREGS_DEF)-1:0]).
- One sub-module, regfile_scoreboard, owns:
  - the busy bit vector, iss_ready, busy_cnt and the set/clear priority.
  - It is instantiated inside regfile_sb, with the storage array and read muxing in the top.

Test Plan:
- Reset-then-read:
  - Stimulus: write 0xDEADBEEF to x5, pulse rst, read x5.
  - Required: rd_data=0, busy_cnt=0.
- x0 handling (ZERO_REG=1):
  - Stimulus: write 0x1234 to x0, then issue iss_rd=0.
  - Required: read x0=0, iss_ready=1, busy_cnt stays 0.
- Scoreboard:
  - Stimulus: issue x7.
  - Required next cycle: rd_busy=1 on a port reading x7, iss_ready=0 for iss_rd=7, busy_cnt=1.
  - Stimulus: writeback x7=0xCAFE0001.
  - Required next cycle: busy clear, busy_cnt=0, read returns 0xCAFE0001.
- Simultaneous:
  - Stimulus: same cycle, writeback x3=0x11 and issue x3 (not busy).
  - Required: busy[x3]=1 and mem[x3]=0x11.
  - Stimulus: same cycle, writeback x4 (busy) and issue x9.
  - Required: busy_cnt unchanged, x4 free, x9 busy.
- Bypass:
  - Stimulus: we=1, wa=10, wd=0xA5A5A5A5, both ports reading x10.
  - Required with REGFILE_BYPASS_EN: both ports show 0xA5A5A5A5 in that cycle.
  - Required without it: both ports show the old value, and 0xA5A5A5A5 the next cycle.
- Parameter sweep:
  - Stimulus: XLEN=64, NREGS=16, NRD=3; fill all registers with pattern {addr, ~addr}; read all ports.
  - Required: every port returns the pattern; busy_cnt reaches 15 after issuing all non-zero registers.

Source files
------------

// File: rtl/regfile_pkg.sv
// regfile_pkg: shared defaults and types for the register file with busy scoreboard.
package regfile_pkg;

    localparam int XLEN_DEF  = 32;
    localparam int NREGS_DEF = 32;

    typedef logic [XLEN_DEF-1:0]          word_t;
    typedef logic [$clog2(NREGS_DEF)-1:0] reg_addr_t;

endpackage

// File: rtl/regfile_sb_if.sv
// regfile_sb_if: decode/writeback-side bundle for regfile_sb.
// Reservation handshake: a reservation transfers on a clk posedge where
// iss_valid && iss_ready. iss_ready is a function of iss_rd and registered
// state only, never of iss_valid, so the requester may sample it before
// deciding to assert iss_valid.
interface regfile_sb_if
    import regfile_pkg::*;
#(
    parameter int XLEN  = XLEN_DEF,
    parameter int NREGS = NREGS_DEF,
    parameter int NRD   = 2
) ();
    localparam int AW = $clog2(NREGS);
    localparam int CW = $clog2(NREGS + 1);

    logic [NRD*AW-1:0]   rd_addr;
    logic [NRD*XLEN-1:0] rd_data;
    logic [NRD-1:0]      rd_busy;
    logic                we;
    logic [AW-1:0]       wa;
    logic [XLEN-1:0]     wd;
    logic                iss_valid;
    logic [AW-1:0]       iss_rd;
    logic                iss_ready;
    logic [CW-1:0]       busy_cnt;

    modport master (
        output rd_addr, we, wa, wd, iss_valid, iss_rd,
        input  rd_data, rd_busy, iss_ready, busy_cnt
    );

    modport slave (
        input  rd_addr, we, wa, wd, iss_valid, iss_rd,
        output rd_data, rd_busy, iss_ready, busy_cnt
    );
endinterface

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: per-register busy bits for long-latency destinations,
// issue readiness and a running busy count. A same-cycle set and clear can
// only target different registers (set needs not-busy, clear needs busy),
// except that set wins if both hit the same register.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int NREGS    = NREGS_DEF,
    parameter int ZERO_REG = 1,
    localparam int AW = $clog2(NREGS),
    localparam int CW = $clog2(NREGS + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we_i,
    input  logic [AW-1:0]    wa_i,
    input  logic             iss_valid_i,
    input  logic [AW-1:0]    iss_rd_i,
    output logic             iss_ready_o,
    output logic [NREGS-1:0] busy_o,
    output logic [CW-1:0]    busy_cnt_o
);

    logic [NREGS-1:0] busy_q, busy_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             iss_zero, set_en, clr_en;

    // Readiness, set/clear decisions and next busy state / count.
    always_comb begin
        iss_zero    = (ZERO_REG != 0) && (iss_rd_i == '0);
        iss_ready_o = !busy_q[iss_rd_i] || iss_zero;
        set_en      = iss_valid_i && iss_ready_o && !iss_zero;
        clr_en      = we_i && busy_q[wa_i];
        busy_d      = busy_q;
        if (clr_en) busy_d[wa_i] = 1'b0;
        if (set_en) busy_d[iss_rd_i] = 1'b1;
        cnt_d = cnt_q;
        case ({set_en, clr_en})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    // Busy state register; reset drops every reservation.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q <= '0;
            cnt_q  <= '0;
        end else begin
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
        end
    end

    assign busy_o     = busy_q;
    assign busy_cnt_o = cnt_q;

endmodule

// File: rtl/regfile_sb.sv
// regfile_sb: integer register file with NRD combinational read ports, one
// synchronous write port and a busy scoreboard for long-latency writebacks.
// Optional macro REGFILE_BYPASS_EN: same-cycle write-through forwarding onto
// read ports whose address matches the active write.
module regfile_sb
    import regfile_pkg::*;
#(
    parameter int XLEN     = XLEN_DEF,
    parameter int NREGS    = NREGS_DEF,
    parameter int NRD      = 2,
    parameter int ZERO_REG = 1
) (
    input logic         clk,
    input logic         rst,
    regfile_sb_if.slave bus
);
    localparam int AW = $clog2(NREGS);

    logic [XLEN-1:0]  mem_q [NREGS];
    logic [NREGS-1:0] busy;
    logic             wr_zero;

    assign wr_zero = (ZERO_REG != 0) && (bus.wa == '0);

    // Storage: clear on reset, otherwise accept writes except to hardwired x0.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) mem_q[i] <= '0;
        end else if (bus.we && !wr_zero) begin
            mem_q[bus.wa] <= bus.wd;
        end
    end

    regfile_scoreboard #(
        .NREGS    (NREGS),
        .ZERO_REG (ZERO_REG)
    ) u_sb (
        .clk         (clk),
        .rst         (rst),
        .we_i        (bus.we),
        .wa_i        (bus.wa),
        .iss_valid_i (bus.iss_valid),
        .iss_rd_i    (bus.iss_rd),
        .iss_ready_o (bus.iss_ready),
        .busy_o      (busy),
        .busy_cnt_o  (bus.busy_cnt)
    );

    for (genvar k = 0; k < NRD; k++) begin : g_rd
        logic [AW-1:0]   addr;
        logic [XLEN-1:0] port_data;
        logic            port_busy;

        assign addr = bus.rd_addr[k*AW +: AW];

        // Read mux: x0 forced to zero, optional forwarding of the active write.
        always_comb begin
            port_data = mem_q[addr];
            port_busy = busy[addr];
`ifdef REGFILE_BYPASS_EN
            if (bus.we && !wr_zero && (bus.wa == addr)) begin
                port_data = bus.wd;
                port_busy = 1'b0;
            end
`endif
            if ((ZERO_REG != 0) && (addr == '0)) begin
                port_data = '0;
                port_busy = 1'b0;
            end
        end

        assign bus.rd_data[k*XLEN +: XLEN] = port_data;
        assign bus.rd_busy[k]              = port_busy;
    end

endmodule
